// File: rtl/riscv_wb_pkg.sv
// Shared constants for the MEM/WB writeback stage: writeback source selects
// and RISC-V load funct3 encodings.
package riscv_wb_pkg;

  // Writeback source select (mem_to_reg)
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data aligner: picks the byte/halfword/word at the load's byte offset
// from a naturally aligned memory word and sign- or zero-extends it to XLEN.
// Misaligned offsets are not trapped; the offset is truncated to the access
// size (low bits ignored for halfword/word).
module load_align
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFS_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [2:0]       load_funct3,
  input  logic [OFS_W-1:0] addr_lsb,
  output logic [XLEN-1:0]  aligned
);

  logic [OFS_W-1:0] w_ofs_h;
  logic [OFS_W-1:0] w_ofs_w;
  logic [XLEN-1:0]  w_sh_b;
  logic [XLEN-1:0]  w_sh_h;
  logic [XLEN-1:0]  w_sh_w;

  // Offsets rounded down to halfword / word boundaries
  assign w_ofs_h = addr_lsb & ~OFS_W'(1);
  assign w_ofs_w = addr_lsb & ~OFS_W'(3);

  // Shift the selected lane down to bit 0
  assign w_sh_b = mem_rdata >> {addr_lsb, 3'b000};
  assign w_sh_h = mem_rdata >> {w_ofs_h, 3'b000};
  assign w_sh_w = mem_rdata >> {w_ofs_w, 3'b000};

  // Extension per load type; unknown or unsupported codes pass the raw word
  always_comb begin
    aligned = mem_rdata;
    case (load_funct3)
      F3_LB:  aligned = XLEN'($signed(w_sh_b[7:0]));
      F3_LBU: aligned = XLEN'(w_sh_b[7:0]);
      F3_LH:  aligned = XLEN'($signed(w_sh_h[15:0]));
      F3_LHU: aligned = XLEN'(w_sh_h[15:0]);
      F3_LW:  aligned = XLEN'($signed(w_sh_w[31:0]));
      F3_LWU: aligned = (XLEN == 64) ? XLEN'(w_sh_w[31:0]) : mem_rdata;
      F3_LD:  aligned = mem_rdata;
      default: aligned = mem_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Registered MEM/WB writeback stage. Selects the writeback value (ALU, aligned
// load, PC+4, immediate), holds it across stalls, kills it on flush, issues a
// single register-file write per instruction and counts retired instructions.
//
// Handshake: in_valid qualifies the MEM-side inputs on a rising edge; the
// instruction is accepted only on an edge with stall=0 and flush=0. stall is
// the backpressure signal (acts as !ready): while high nothing is accepted and
// the MEM/WB contents hold. flush discards whatever would be captured and
// clears the stage, taking priority over stall.
module writeback_stage
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32,
  parameter int OFS_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             reg_write,
  input  logic [4:0]       rd_addr,
  input  logic [1:0]       mem_to_reg,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [2:0]       load_funct3,
  input  logic [OFS_W-1:0] addr_lsb,
  input  logic [XLEN-1:0]  pc_plus_4,
  input  logic [XLEN-1:0]  immediate,
  output logic             wb_valid,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_wb_data;
  logic             w_rf_we;

  logic             r_wb_valid;
  logic             r_reg_write;
  logic [4:0]       r_waddr;
  logic [XLEN-1:0]  r_wdata;
  logic             r_written;
  logic [CNT_W-1:0] r_instret;

  load_align #(
    .XLEN  (XLEN),
    .OFS_W (OFS_W)
  ) u_load_align (
    .mem_rdata   (mem_rdata),
    .load_funct3 (load_funct3),
    .addr_lsb    (addr_lsb),
    .aligned     (w_load)
  );

  // Writeback source select
  always_comb begin
    w_wb_data = alu_result;
    case (mem_to_reg)
      WB_ALU: w_wb_data = alu_result;
      WB_MEM: w_wb_data = w_load;
      WB_PC4: w_wb_data = pc_plus_4;
      WB_IMM: w_wb_data = immediate;
      default: w_wb_data = alu_result;
    endcase
  end

  // One write per instruction: r_written blocks repeats while stalled; x0 is never written
  assign w_rf_we = r_wb_valid & r_reg_write & (r_waddr != 5'd0) & ~r_written;

  // MEM/WB register with flush > stall > capture priority, plus retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid  <= 1'b0;
      r_reg_write <= 1'b0;
      r_waddr     <= 5'd0;
      r_wdata     <= '0;
      r_written   <= 1'b0;
      r_instret   <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
      r_written  <= 1'b0;
    end else if (stall) begin
      if (w_rf_we) begin
        r_written <= 1'b1;
      end
    end else begin
      r_wb_valid  <= in_valid;
      r_reg_write <= reg_write;
      r_waddr     <= rd_addr;
      r_wdata     <= w_wb_data;
      r_written   <= 1'b0;
      if (in_valid) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign rf_we    = w_rf_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign instret  = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: XLEN=32 main instance, a CNT_W=4 instance
// sharing its inputs for counter wrap, and an XLEN=64 instance for 64-bit loads.
module tb_writeback_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared control
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       reg_write = 1'b1;
  logic [4:0] rd_addr = 5'd0;
  logic [1:0] mem_to_reg = 2'b00;
  logic [2:0] load_funct3 = 3'b010;

  // 32-bit data
  logic [31:0] alu32 = '0, mem32 = '0, pc32 = '0, imm32 = '0;
  logic [1:0]  lsb32 = '0;
  // 64-bit data
  logic [63:0] mem64 = '0;
  logic [2:0]  lsb64 = '0;
  logic [63:0] zero64 = '0;

  // outputs
  logic        wbv32, we32; logic [4:0] wa32; logic [31:0] wd32; logic [31:0] ret32;
  logic        wbv4,  we4;  logic [4:0] wa4;  logic [31:0] wd4;  logic [3:0]  ret4;
  logic        wbv64, we64; logic [4:0] wa64; logic [63:0] wd64; logic [31:0] ret64;

  writeback_stage #(.XLEN(32), .CNT_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .reg_write(reg_write), .rd_addr(rd_addr), .mem_to_reg(mem_to_reg),
    .alu_result(alu32), .mem_rdata(mem32), .load_funct3(load_funct3),
    .addr_lsb(lsb32), .pc_plus_4(pc32), .immediate(imm32),
    .wb_valid(wbv32), .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32), .instret(ret32)
  );

  writeback_stage #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .reg_write(reg_write), .rd_addr(rd_addr), .mem_to_reg(mem_to_reg),
    .alu_result(alu32), .mem_rdata(mem32), .load_funct3(load_funct3),
    .addr_lsb(lsb32), .pc_plus_4(pc32), .immediate(imm32),
    .wb_valid(wbv4), .rf_we(we4), .rf_waddr(wa4), .rf_wdata(wd4), .instret(ret4)
  );

  writeback_stage #(.XLEN(64), .CNT_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .reg_write(reg_write), .rd_addr(rd_addr), .mem_to_reg(mem_to_reg),
    .alu_result(zero64), .mem_rdata(mem64), .load_funct3(load_funct3),
    .addr_lsb(lsb64), .pc_plus_4(zero64), .immediate(zero64),
    .wb_valid(wbv64), .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64), .instret(ret64)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wbv"}, 64'(wbv32), 64'd0);
    check({tag, ".we"},  64'(we32),  64'd0);
    check({tag, ".wa"},  64'(wa32),  64'd0);
    check({tag, ".wd"},  64'(wd32),  64'd0);
    check({tag, ".ret"}, 64'(ret32), 64'd0);
    check({tag, ".ret4"}, 64'(ret4), 64'd0);
    check({tag, ".wd64"}, wd64,      64'd0);
  endtask

  typedef struct { logic [2:0] f3; logic [1:0] lsb; logic [31:0] exp; } ld_vec_t;
  ld_vec_t ld_tbl [5];

  typedef struct { logic [2:0] f3; logic [2:0] lsb; logic [63:0] exp; } ld64_vec_t;
  ld64_vec_t ld64_tbl [4];

  logic [31:0] held_wd;

  initial begin
    ld_tbl[0] = '{3'b000, 2'd3, 32'hFFFFFF80};
    ld_tbl[1] = '{3'b100, 2'd3, 32'h00000080};
    ld_tbl[2] = '{3'b001, 2'd2, 32'hFFFF80FF};
    ld_tbl[3] = '{3'b101, 2'd0, 32'h00007F01};
    ld_tbl[4] = '{3'b000, 2'd1, 32'h0000007F};

    ld64_tbl[0] = '{3'b010, 3'd0, 64'h0000000012345678};
    ld64_tbl[1] = '{3'b010, 3'd4, 64'hFFFFFFFF80000000};
    ld64_tbl[2] = '{3'b110, 3'd4, 64'h0000000080000000};
    ld64_tbl[3] = '{3'b011, 3'd0, 64'h8000000012345678};

    // ---- reset ----
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #2 rst_n = 1'b1;
    step();

    // ---- 1: source select sweep ----
    alu32 = 32'hAAAAAAAA; mem32 = 32'hBBBBBBBB; pc32 = 32'hCCCCCCCC; imm32 = 32'hDDDDDDDD;
    load_funct3 = 3'b010; lsb32 = 2'd0; rd_addr = 5'd5; reg_write = 1'b1; in_valid = 1'b1;
    exp_q.push_back(64'hAAAAAAAA); exp_q.push_back(64'hBBBBBBBB);
    exp_q.push_back(64'hCCCCCCCC); exp_q.push_back(64'hDDDDDDDD);
    for (int m = 0; m < 4; m++) begin
      mem_to_reg = 2'(m);
      step();
      exp_ret++;
      check("sel.wd", 64'(wd32), exp_q.pop_front());
      check("sel.wa", 64'(wa32), 64'd5);
      check("sel.we", 64'(we32), 64'd1);
    end
    check("sel.ret", 64'(ret32), 64'(exp_ret));

    // ---- 2: load extension ----
    mem32 = 32'h80FF7F01; mem_to_reg = 2'b01;
    for (int i = 0; i < 5; i++) begin
      load_funct3 = ld_tbl[i].f3;
      lsb32 = ld_tbl[i].lsb;
      step();
      exp_ret++;
      check($sformatf("ld%0d.wd", i), 64'(wd32), 64'(ld_tbl[i].exp));
    end

    // ---- 3: stall, single write pulse ----
    mem_to_reg = 2'b00; alu32 = 32'h12345678; rd_addr = 5'd7;
    step();
    exp_ret++;
    held_wd = 32'h12345678;
    stall = 1'b1;
    alu32 = 32'h0BADF00D; rd_addr = 5'd9;   // must not be captured
    check("stl0.we", 64'(we32), 64'd1);
    check("stl0.wd", 64'(wd32), 64'(held_wd));
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("stl%0d.we", c), 64'(we32), 64'd0);
      check($sformatf("stl%0d.wd", c), 64'(wd32), 64'(held_wd));
      check($sformatf("stl%0d.wa", c), 64'(wa32), 64'd7);
      check($sformatf("stl%0d.wbv", c), 64'(wbv32), 64'd1);
      check($sformatf("stl%0d.ret", c), 64'(ret32), 64'(exp_ret));
    end
    stall = 1'b0; in_valid = 1'b0;
    step();
    check("stlrel.wbv", 64'(wbv32), 64'd0);
    check("stlrel.we", 64'(we32), 64'd0);
    check("stlrel.ret", 64'(ret32), 64'(exp_ret));

    // ---- 4: flush beats stall; x0 ----
    in_valid = 1'b1; stall = 1'b1; flush = 1'b1; rd_addr = 5'd9;
    step();
    check("flush.wbv", 64'(wbv32), 64'd0);
    check("flush.we", 64'(we32), 64'd0);
    check("flush.ret", 64'(ret32), 64'(exp_ret));
    stall = 1'b0; flush = 1'b0; rd_addr = 5'd0; reg_write = 1'b1;
    step();
    exp_ret++;
    check("x0.wbv", 64'(wbv32), 64'd1);
    check("x0.we", 64'(we32), 64'd0);
    check("x0.ret", 64'(ret32), 64'(exp_ret));

    // ---- 5: counter wrap and reset mid-stall ----
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("rst2");
    #2 rst_n = 1'b1;
    rd_addr = 5'd3; in_valid = 1'b1;
    repeat (17) step();
    check("wrap.ret4", 64'(ret4), 64'd1);
    check("wrap.ret32", 64'(ret32), 64'd17);
    stall = 1'b1;
    check("pre.we", 64'(we32), 64'd1);
    step();
    check("pre2.we", 64'(we32), 64'd0);
    #2 rst_n = 1'b0;
    #1 check_zero("rstmid");
    #2 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("post%0d.we", c), 64'(we32), 64'd0);
    end
    stall = 1'b0; in_valid = 1'b0;
    step();
    check("post.we", 64'(we32), 64'd0);
    check("post.wbv", 64'(wbv32), 64'd0);

    // ---- 6: XLEN=64 loads ----
    mem64 = 64'h8000000012345678; mem_to_reg = 2'b01; in_valid = 1'b1; rd_addr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      load_funct3 = ld64_tbl[i].f3;
      lsb64 = ld64_tbl[i].lsb;
      step();
      check($sformatf("ld64_%0d.wd", i), wd64, ld64_tbl[i].exp);
      check($sformatf("ld64_%0d.we", i), 64'(we64), 64'd1);
    end

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered MEM/WB writeback stage of the RISC-V pipeline.
- Aligns and sign/zero-extends load data, then selects the writeback source (ALU, memory, PC+4, immediate).
- Drives the register-file write port with a one-shot write enable, and counts retired instructions.
- Generalises the combinational writeback mux in width and source handling, and adds stall/flush buffering.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNT_W, 32, width of the retired-instruction counter.
- OFS_W, $clog2(XLEN/8), width of the address byte offset (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the current MEM/WB contents
- flush  in  1  kill the instruction being captured
- in_valid  in  1  MEM-stage instruction is valid
- reg_write  in  1  instruction writes rd
- rd_addr  in  5  destination register
- mem_to_reg  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 IMM
- alu_result  in  XLEN  ALU result
- mem_rdata  in  XLEN  raw, naturally aligned memory word
- load_funct3  in  3  load type
- addr_lsb  in  OFS_W  byte offset of the load address
- pc_plus_4  in  XLEN  link value for JAL/JALR
- immediate  in  XLEN  LUI immediate
- wb_valid  out  1  MEM/WB register holds a valid instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): wb_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, instret=0, internal written flag=0. Outputs stay zero while rst_n=0.
- Data path before the register (combinational), with bytes taken at offset addr_lsb:
  - LB (000): byte sign-extended.
  - LBU (100): byte zero-extended.
  - LH (001): halfword at addr_lsb[OFS_W-1:1] sign-extended.
  - LHU (101): halfword at addr_lsb[OFS_W-1:1] zero-extended.
  - LW (010): word sign-extended to XLEN.
  - LWU (110): word zero-extended; XLEN=64 only.
  - LD (011): full doubleword; XLEN=64 only.
  - Any other funct3, or a 64-bit-only code when XLEN=32: pass mem_rdata unmodified.
  - Misaligned offsets are not checked; the low bits are used as given.
- Source mux selects ALU, aligned load, PC+4 or immediate per mem_to_reg.
- Latency: one cycle from the MEM-side inputs to rf_wdata, rf_waddr and wb_valid.
- Each rising edge, in priority order:
  - flush=1: wb_valid<=0, written<=0; the data registers may update but are don't-care. Flush beats stall.
  - else stall=1: every register holds. written<=1 if rf_we was 1 this cycle.
  - else: wb_valid<=in_valid; capture rd_addr, the muxed data and reg_write; written<=0. instret<=instret+1 when in_valid=1, wrapping modulo 2^CNT_W.
- rf_we = wb_valid & reg_write_q & (rf_waddr!=0) & ~written.
  - This gives exactly one write pulse per instruction, even across a multi-cycle stall.
  - x0 is never written, but an x0 instruction still counts in instret.
- A flushed or invalid instruction never increments instret and never asserts rf_we.
- Simultaneous stall and flush: treated as flush.
- Reset mid-stall: the held instruction is discarded; no write occurs after release.

Decomposition:
- Package riscv_wb_pkg holds:
  - Writeback-select constants WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10, WB_IMM=2'b11.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU.
- One sub-module: load_align (combinational; parameter XLEN; inputs mem_rdata, load_funct3, addr_lsb; output aligned data).
- The 4:1 mux, pipeline register, written flag and counter live in writeback_stage.

Test Plan:
1. Source select, XLEN=32: alu=AAAAAAAA, mem=BBBBBBBB (LW, lsb=0), pc4=CCCCCCCC, imm=DDDDDDDD, rd=5, in_valid=1; sweep mem_to_reg 00..11 -> one cycle later rf_wdata is AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD in turn, rf_waddr=5, rf_we=1 each cycle, instret=4.
2. Load extension: mem_rdata=80FF7F01, mem_to_reg=01:
   - LB, lsb=3 -> FFFFFF80
   - LBU, lsb=3 -> 00000080
   - LH, lsb=2 -> FFFF80FF
   - LHU, lsb=0 -> 00007F01
   - LB, lsb=1 -> 0000007F
3. Stall: capture rd=7, data=12345678, then hold stall=1 for 3 cycles -> rf_we high for exactly 1 cycle; rf_wdata and wb_valid held all 3 cycles; instret +1 only.
4. Flush vs stall: stall=1 and flush=1 in the same cycle -> next cycle wb_valid=0, rf_we=0, instret unchanged. An x0 instruction (rd=0, reg_write=1) -> rf_we=0, instret +1.
5. Reset/wrap: CNT_W=4, retire 17 valid instructions -> instret=1. Assert rst_n=0 mid-stall, asynchronously between edges -> all outputs 0 immediately; after release no rf_we pulse.
6. XLEN=64: mem_rdata=8000000012345678:
   - LW, lsb=0 -> 0000000012345678
   - LW, lsb=4 -> FFFFFFFF80000000
   - LWU, lsb=4 -> 0000000080000000
   - LD -> 8000000012345678
